// File: rtl/sequence_checker_if.sv
// Stream-in / verdict-out bundle for the recurrence sequence checker.
// The slave view belongs to the checker; the master view belongs to the producer/consumer.
interface sequence_checker_if #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_match;
   logic [CNT_W-1:0] out_index;
   logic [WIDTH-1:0] out_expected;
   logic             locked;
   logic [CNT_W-1:0] err_count;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_match, out_index, out_expected, locked, err_count
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_match, out_index, out_expected, locked, err_count
   );
endinterface

// File: rtl/sequence_checker.sv
// Checks a received stream against a(n) = a(n-1) + a(n-5) seeded 0,1,1,1,2,
// emitting one registered verdict per accepted term plus saturating counters.
module sequence_checker #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 32
) (
   input logic               clk,
   input logic               reset,
   sequence_checker_if.slave bus
);
   typedef enum logic {SEED, TRACK} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] hist_q [5];
   logic [WIDTH-1:0] hist_d [5];
   logic [2:0]       seed_pos_q, seed_pos_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             locked_q, locked_d;
   logic             out_valid_q, out_valid_d;
   logic             out_match_q, out_match_d;
   logic [CNT_W-1:0] out_index_q, out_index_d;
   logic [WIDTH-1:0] out_expected_q, out_expected_d;

   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] seed_val;
   logic [WIDTH-1:0] expected;
   logic             is_match;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      case (seed_pos_q)
         3'd0:    seed_val = '0;
         3'd4:    seed_val = WIDTH'(2);
         default: seed_val = WIDTH'(1);
      endcase
   end

   // Single unpipelined add; the carry out of the top bit is dropped.
   assign expected = (state_q == SEED) ? seed_val : hist_q[4] + hist_q[0];
   assign is_match = (bus.in_data == expected);

   always_comb begin
      // NOTE: every *_d starts as its *_q so no branch leaves a signal unassigned and infers a latch.
      state_d        = state_q;
      hist_d         = hist_q;
      seed_pos_d     = seed_pos_q;
      idx_d          = idx_q;
      err_d          = err_q;
      locked_d       = locked_q;
      out_valid_d    = out_valid_q;
      out_match_d    = out_match_q;
      out_index_d    = out_index_q;
      out_expected_d = out_expected_q;

      if (accept) begin
         out_valid_d    = 1'b1;
         out_match_d    = is_match;
         out_index_d    = idx_q;
         out_expected_d = expected;
         if (is_match) begin
            for (int i = 0; i < 4; i++) hist_d[i] = hist_q[i + 1];
            hist_d[4] = bus.in_data;
            idx_d     = (&idx_q) ? idx_q : idx_q + 1'b1;
            if (state_q == SEED) begin
               if (seed_pos_q == 3'd4) begin
                  state_d    = TRACK;
                  locked_d   = 1'b1;
                  seed_pos_d = 3'd0;
               end else begin
                  seed_pos_d = seed_pos_q + 3'd1;
               end
            end
         end else begin
            err_d    = (&err_q) ? err_q : err_q + 1'b1;
            locked_d = 1'b0;
            state_d  = SEED;
            // A zero that breaks the stream is taken as a fresh seed 0.
            if (bus.in_data == '0) begin
               seed_pos_d = 3'd1;
               hist_d[4]  = '0;
               idx_d      = CNT_W'(1);
            end else begin
               seed_pos_d = 3'd0;
               idx_d      = '0;
            end
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= SEED;
         // NOTE: the history is only five words and must read zero after reset, so it is reset like any flop.
         for (int i = 0; i < 5; i++) hist_q[i] <= '0;
         seed_pos_q     <= '0;
         idx_q          <= '0;
         err_q          <= '0;
         locked_q       <= 1'b0;
         out_valid_q    <= 1'b0;
         out_match_q    <= 1'b0;
         out_index_q    <= '0;
         out_expected_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state_q        <= state_d;
         hist_q         <= hist_d;
         seed_pos_q     <= seed_pos_d;
         idx_q          <= idx_d;
         err_q          <= err_d;
         locked_q       <= locked_d;
         out_valid_q    <= out_valid_d;
         out_match_q    <= out_match_d;
         out_index_q    <= out_index_d;
         out_expected_q <= out_expected_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_match    = out_match_q;
   assign bus.out_index    = out_index_q;
   assign bus.out_expected = out_expected_q;
   assign bus.locked       = locked_q;
   assign bus.err_count    = err_q;
endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench: a 64-bit checker and an 8-bit/4-bit-counter checker see the same
// stream; a sequence-level model predicts every verdict and a monitor compares them.
module tb_sequence_checker;
   localparam int W0 = 64, C0 = 32, W1 = 8, C1 = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   sequence_checker_if #(.WIDTH(W0), .CNT_W(C0)) b64 ();
   sequence_checker_if #(.WIDTH(W1), .CNT_W(C1)) b8 ();

   assign b64.in_valid  = in_valid;
   assign b64.in_data   = in_data;
   assign b64.out_ready = out_ready;
   assign b8.in_valid   = in_valid;
   assign b8.in_data    = in_data[7:0];
   assign b8.out_ready  = out_ready;

   sequence_checker #(.WIDTH(W0), .CNT_W(C0)) dut64 (.clk(clk), .reset(reset), .bus(b64));
   sequence_checker #(.WIDTH(W1), .CNT_W(C1)) dut8  (.clk(clk), .reset(reset), .bus(b8));

   typedef struct packed {
      logic        match;
      logic [31:0] index;
      logic [63:0] expected;
      logic        locked;
      logic [31:0] err;
   } verdict_t;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: the sequence since the last sync ----------------
   logic [63:0]     seq_mem [2][1024];
   int              n_m [2];
   longint unsigned err_m [2];
   verdict_t        q0[$];
   verdict_t        q1[$];

   function automatic logic [63:0] seed_of(input int p);
      if (p == 0) return 64'd0;
      if (p == 4) return 64'd2;
      return 64'd1;
   endfunction

   function automatic logic [63:0] gen_term(input int i);
      logic [63:0] a [64];
      for (int j = 0; j < 5; j++) a[j] = seed_of(j);
      for (int j = 5; j <= i; j++) a[j] = a[j-1] + a[j-5];
      return a[i];
   endfunction

   function automatic verdict_t model_step(input int k, input logic [63:0] raw);
      verdict_t        v;
      logic [63:0]     wm;
      logic [31:0]     cm;
      logic [63:0]     d, e;
      int              n;
      longint unsigned nl;
      wm = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
      cm = (k == 0) ? 32'hFFFF_FFFF : 32'hF;
      d  = raw & wm;
      n  = n_m[k];
      nl = longint'(n);
      if (n < 5) e = seed_of(n);
      else       e = (seq_mem[k][(n-1) % 1024] + seq_mem[k][(n-5) % 1024]) & wm;
      v.expected = e;
      v.index    = (nl > {32'd0, cm}) ? cm : nl[31:0];
      if (d == e) begin
         v.match = 1'b1;
         seq_mem[k][n % 1024] = d;
         n_m[k] = n + 1;
      end else begin
         v.match = 1'b0;
         if (err_m[k] < {32'd0, cm}) err_m[k]++;
         if (d == 64'd0) begin
            seq_mem[k][0] = 64'd0;
            n_m[k] = 1;
         end else begin
            n_m[k] = 0;
         end
      end
      v.locked = (n_m[k] >= 5);
      v.err    = err_m[k][31:0];
      return v;
   endfunction

   task automatic push_term(input logic [63:0] raw);
      q0.push_back(model_step(0, raw));
      q1.push_back(model_step(1, raw));
   endtask

   logic     held [2] = '{1'b0, 1'b0};
   verdict_t held_v [2];

   task automatic clear_sb();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         n_m[k]   = 0;
         err_m[k] = 0;
         held[k]  = 1'b0;
      end
   endtask

   // ---------------- monitor ----------------
   task automatic mon(input int k, input logic ov, input logic ir, input verdict_t got);
      string    nm;
      verdict_t e;
      nm = (k == 0) ? "w64" : "w8";
      check({nm, " in_ready"}, ir, !ov || out_ready);
      if (held[k]) begin
         check({nm, " hold valid"}, ov, 1'b1);
         check({nm, " hold stable"}, got, held_v[k]);
      end
      held[k]   = ov && !out_ready;
      held_v[k] = got;
      if (ov && out_ready) begin
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected verdict: index %0d with nothing outstanding", nm, got.index);
         end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check({nm, " match"},    got.match,    e.match);
            check({nm, " index"},    got.index,    e.index);
            check({nm, " expected"}, got.expected, e.expected);
            check({nm, " locked"},   got.locked,   e.locked);
            check({nm, " err"},      got.err,      e.err);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mon(0, b64.out_valid, b64.in_ready,
             {b64.out_match, 32'(b64.out_index), b64.out_expected, b64.locked, 32'(b64.err_count)});
         mon(1, b8.out_valid, b8.in_ready,
             {b8.out_match, 32'(b8.out_index), 64'(b8.out_expected), b8.locked, 32'(b8.err_count)});
      end
   end

   // ---------------- stimulus ----------------
   int bp_pct = 0;
   int stall_left = 0;

   task automatic send(input logic [63:0] d);
      int   waits;
      logic acc;
      waits    = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!acc && waits < 200) begin
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) >= bp_pct);
         end
         @(negedge clk);
         acc = b64.in_ready;
         @(posedge clk);
         #1;
         waits++;
      end
      if (acc) push_term(d);
      else begin
         checks++;
         failures++;
         $display("FAIL send timeout: term %0h never accepted", d);
      end
   endtask

   task automatic idle(input int c);
      in_valid = 1'b0;
      repeat (c) begin
         out_ready = ($urandom_range(99) >= bp_pct);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q0.size() != 0 || q1.size() != 0) && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain timeout: %0d/%0d verdicts outstanding", q0.size(), q1.size());
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " w64 out_valid"},    b64.out_valid,    0);
      check({tag, " w64 out_match"},    b64.out_match,    0);
      check({tag, " w64 out_index"},    b64.out_index,    0);
      check({tag, " w64 out_expected"}, b64.out_expected, 0);
      check({tag, " w64 locked"},       b64.locked,       0);
      check({tag, " w64 err_count"},    b64.err_count,    0);
      check({tag, " w8 out_valid"},     b8.out_valid,     0);
      check({tag, " w8 err_count"},     b8.err_count,     0);
      check({tag, " w8 out_index"},     b8.out_index,     0);
   endtask

   task automatic apply_reset(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      clear_sb();
      check_zero(tag);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int          len, p;

      #1;
      clear_sb();
      check_zero("por");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Clean stream through index 22; the 8-bit checker sees 265 as 9 and its index saturates at 15.
      for (int i = 0; i <= 22; i++) send(gen_term(i));
      drain();
      check("clean w64 err",      b64.err_count,    0);
      check("clean w64 locked",   b64.locked,       1);
      check("clean w64 index",    b64.out_index,    22);
      check("clean w64 expected", b64.out_expected, 265);
      check("clean w8 index",     b8.out_index,     15);
      check("clean w8 expected",  b8.out_expected,  9);
      check("clean w8 match",     b8.out_match,     1);

      // Wrong value at index 22 in 8-bit terms: 266 truncates to 10, expected 9.
      apply_reset("rst1");
      for (int i = 0; i <= 21; i++) send(gen_term(i));
      send(64'd266);
      drain();
      check("wrap w8 match",    b8.out_match,    0);
      check("wrap w8 expected", b8.out_expected, 9);
      check("wrap w8 err",      b8.err_count,    1);

      // Reset mid-stream with a verdict held in the register.
      apply_reset("rst2");
      for (int i = 0; i <= 7; i++) send(gen_term(i));
      check("held before reset", b64.out_valid, 1);
      apply_reset("midrst");
      send(64'd0);
      drain();
      check("after reset match", b64.out_match, 1);
      check("after reset index", b64.out_index, 0);

      // Corruption at index 10, two more SEED mismatches, then resync.
      for (int i = 1; i <= 9; i++) send(gen_term(i));
      send(64'd10);
      send(gen_term(11));
      send(gen_term(12));
      drain();
      check("corrupt w64 err",    b64.err_count, 3);
      check("corrupt w64 locked", b64.locked,    0);
      for (int i = 0; i <= 6; i++) send(gen_term(i));
      drain();
      check("resync w64 err",    b64.err_count, 3);
      check("resync w64 locked", b64.locked,    1);
      check("resync w64 index",  b64.out_index, 6);

      // Three-cycle output stall mid-stream with input pending.
      apply_reset("rst3");
      for (int i = 0; i <= 15; i++) begin
         if (i == 6) stall_left = 3;
         send(gen_term(i));
      end
      drain();

      // Randomised runs: backpressure, gaps, bit flips and stray zeros.
      bp_pct = 30;
      for (int r = 0; r < 30; r++) begin
         len = $urandom_range(40, 5);
         for (int i = 0; i < len; i++) begin
            v = gen_term(i);
            p = $urandom_range(99);
            if (p < 6)      v = v ^ (64'd1 << $urandom_range(63));
            else if (p < 9) v = 64'd0;
            send(v);
            if ($urandom_range(9) == 0) idle($urandom_range(3, 1));
         end
         if ((r % 5) == 4) drain();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
